// File: rtl/rock_strategy_fsm_pkg.sv
// Shared types and level limits for the rocking controller.
// Pure declarations: no logic, no latency, no flow control.
package rock_pkg;

    localparam int LVL_W = 3;
    localparam logic [LVL_W-1:0] LVL_MIN = 3'd1;
    localparam logic [LVL_W-1:0] LVL_MAX = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_EVAL   = 2'd2,
        ST_CALM   = 2'd3
    } state_t;

    typedef enum logic {
        KNOB_AMP  = 1'b0,
        KNOB_FREQ = 1'b1
    } knob_t;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_t;

endpackage

// File: rtl/rock_strategy_fsm_if.sv
// Stress-sample inputs and motor set-point outputs of the rocking controller.
// master drives the samples and enable; slave is the controller.
interface rock_strategy_fsm_if;
    import rock_pkg::*;

    logic             enable;
    logic             sample_tick;
    logic [2:0]       status;
    logic             gedaald;
    logic             gelijk;
    logic [LVL_W-1:0] amp;
    logic [LVL_W-1:0] freq;
    logic             busy;
    logic             calm;
    logic             alarm;

    modport master (
        output enable, sample_tick, status, gedaald, gelijk,
        input  amp, freq, busy, calm, alarm
    );

    modport slave (
        input  enable, sample_tick, status, gedaald, gelijk,
        output amp, freq, busy, calm, alarm
    );

endinterface

// File: rtl/rock_strategy_fsm_level_stepper.sv
// Saturating +/-1 on a set-point level; flags when the step is blocked at a limit.
// Combinational, zero latency; no flow control.
module level_stepper
    import rock_pkg::*;
(
    input  logic [LVL_W-1:0] lvl_i,
    input  dir_t             dir_i,
    output logic [LVL_W-1:0] lvl_o,
    output logic             sat_o
);

    always_comb begin
        sat_o = (dir_i == DIR_UP) ? (lvl_i >= LVL_MAX) : (lvl_i <= LVL_MIN);
        lvl_o = lvl_i;
        if (!sat_o) begin
            lvl_o = (dir_i == DIR_UP) ? lvl_i + 1'b1 : lvl_i - 1'b1;
        end
    end

endmodule

// File: rtl/rock_strategy_fsm.sv
// Closed-loop rocking controller: steps either amp or freq per round, judging stress after each settle window.
// Set-points update one cycle after EVAL; ROCK_WATCHDOG_EN adds a fail counter that raises alarm.
module rock_strategy_fsm
    import rock_pkg::*;
#(
    parameter int SETTLE_SAMPLES = 8,
    parameter int START_AMP      = 2,
    parameter int START_FREQ     = 2,
    parameter int MAX_FAIL       = 4
) (
    input  logic              clk,
    input  logic              reset,
    rock_strategy_fsm_if.slave rif
);

    localparam logic [LVL_W-1:0] START_AMP_L  = LVL_W'(START_AMP);
    localparam logic [LVL_W-1:0] START_FREQ_L = LVL_W'(START_FREQ);
    localparam logic [7:0]       SETTLE_L     = 8'(SETTLE_SAMPLES);

    state_t           state_q, state_d;
    logic [LVL_W-1:0] amp_q, amp_d, freq_q, freq_d;
    knob_t            knob_q, knob_d, knob_eff;
    dir_t             dir_q, dir_d, dir_eff;
    logic [7:0]       cnt_q, cnt_d;
    logic [LVL_W-1:0] step_in, step_out;
    logic             step_sat;

`ifdef ROCK_WATCHDOG_EN
    localparam logic [7:0] FAIL_L = 8'(MAX_FAIL);
    logic [7:0] fail_q, fail_d;
    logic       alarm_q, alarm_d;
`endif

    // Set-point selection and direction the EVAL step would use, from the current flags.
    always_comb begin
        knob_eff = knob_q;
        dir_eff  = dir_q;
        if (!rif.gedaald) begin
            knob_eff = knob_t'(~knob_q);
            if (!rif.gelijk) begin
                dir_eff = dir_t'(~dir_q);
            end
        end
        step_in = (knob_eff == KNOB_FREQ) ? freq_q : amp_q;
    end

    level_stepper u_stepper (
        .lvl_i (step_in),
        .dir_i (dir_eff),
        .lvl_o (step_out),
        .sat_o (step_sat)
    );

    always_comb begin
        state_d = state_q;
        amp_d   = amp_q;
        freq_d  = freq_q;
        knob_d  = knob_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
`ifdef ROCK_WATCHDOG_EN
        fail_d  = fail_q;
        alarm_d = alarm_q;
`endif
        unique case (state_q)
            ST_IDLE: begin
`ifdef ROCK_WATCHDOG_EN
                fail_d  = 8'd0;
                alarm_d = 1'b0;
`endif
                if (rif.enable) begin
                    amp_d   = START_AMP_L;
                    freq_d  = START_FREQ_L;
                    cnt_d   = 8'd0;
                    state_d = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (rif.sample_tick) begin
                    cnt_d = cnt_q + 8'd1;
                    if (cnt_q + 8'd1 == SETTLE_L) begin
                        state_d = ST_EVAL;
                    end
                end
            end
            ST_EVAL: begin
                if (rif.status == 3'd0) begin
                    state_d = ST_CALM;
`ifdef ROCK_WATCHDOG_EN
                    fail_d  = 8'd0;
`endif
                end else begin
                    if (knob_eff == KNOB_FREQ) begin
                        freq_d = step_out;
                    end else begin
                        amp_d = step_out;
                    end
                    knob_d  = knob_eff;
                    dir_d   = step_sat ? dir_t'(~dir_eff) : dir_eff;
                    cnt_d   = 8'd0;
                    state_d = ST_SETTLE;
`ifdef ROCK_WATCHDOG_EN
                    if (rif.gedaald) begin
                        fail_d = 8'd0;
                    end else if (fail_q + 8'd1 >= FAIL_L) begin
                        // Trip: abandon the search and restart from known-good settings.
                        fail_d  = 8'd0;
                        alarm_d = 1'b1;
                        amp_d   = START_AMP_L;
                        freq_d  = START_FREQ_L;
                        knob_d  = KNOB_AMP;
                        dir_d   = DIR_UP;
                    end else begin
                        fail_d = fail_q + 8'd1;
                    end
`endif
                end
            end
            ST_CALM: begin
`ifdef ROCK_WATCHDOG_EN
                fail_d = 8'd0;
`endif
                if (rif.sample_tick && rif.status != 3'd0) begin
                    cnt_d   = 8'd0;
                    state_d = ST_SETTLE;
                end
            end
        endcase

        // Dropping enable overrides everything, including a pending EVAL step.
        if (!rif.enable) begin
            state_d = ST_IDLE;
            amp_d   = '0;
            freq_d  = '0;
            knob_d  = KNOB_AMP;
            dir_d   = DIR_UP;
            cnt_d   = 8'd0;
`ifdef ROCK_WATCHDOG_EN
            fail_d  = 8'd0;
            alarm_d = 1'b0;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            amp_q   <= '0;
            freq_q  <= '0;
            knob_q  <= KNOB_AMP;
            dir_q   <= DIR_UP;
            cnt_q   <= 8'd0;
`ifdef ROCK_WATCHDOG_EN
            fail_q  <= 8'd0;
            alarm_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            amp_q   <= amp_d;
            freq_q  <= freq_d;
            knob_q  <= knob_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
`ifdef ROCK_WATCHDOG_EN
            fail_q  <= fail_d;
            alarm_q <= alarm_d;
`endif
        end
    end

    assign rif.amp  = amp_q;
    assign rif.freq = freq_q;
    assign rif.busy = (state_q == ST_SETTLE) || (state_q == ST_EVAL);
    assign rif.calm = (state_q == ST_CALM);
`ifdef ROCK_WATCHDOG_EN
    assign rif.alarm = alarm_q;
`else
    // Constant low; the comparison only keeps MAX_FAIL referenced.
    assign rif.alarm = (MAX_FAIL < 0);
`endif

endmodule

// File: tb/tb_rock_strategy_fsm.sv
// Bench for rock_strategy_fsm with SETTLE_SAMPLES=2, START 2/2, MAX_FAIL=4.
module tb_rock_strategy_fsm;
    import rock_pkg::*;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    rock_strategy_fsm_if rif();

    rock_strategy_fsm #(
        .SETTLE_SAMPLES (2),
        .START_AMP      (2),
        .START_FREQ     (2),
        .MAX_FAIL       (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .rif   (rif)
    );

    typedef struct {
        string      tag;
        logic [2:0] amp;
        logic [2:0] freq;
        logic       busy;
        logic       calm;
        logic       alarm;
    } exp_t;

    typedef struct {
        logic [2:0] st;
        logic       g;
        logic       e;
        logic [2:0] amp;
        logic [2:0] freq;
        logic       busy;
        logic       calm;
    } vec_t;

    exp_t exp_q[$];
    vec_t tbl[14];
    int   checks = 0;
    int   errors = 0;
    logic wd;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic [2:0] a, input logic [2:0] f,
                              input logic b, input logic c, input logic al);
        exp_t x;
        x.tag = tag; x.amp = a; x.freq = f; x.busy = b; x.calm = c; x.alarm = al;
        exp_q.push_back(x);
    endtask

    task automatic check_out();
        exp_t x;
        logic [8:0] act, req;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL scoreboard_empty: no expectation queued");
            return;
        end
        x   = exp_q.pop_front();
        act = {rif.amp, rif.freq, rif.busy, rif.calm, rif.alarm};
        req = {x.amp, x.freq, x.busy, x.calm, x.alarm};
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got amp=%0d freq=%0d busy=%b calm=%b alarm=%b, want amp=%0d freq=%0d busy=%b calm=%b alarm=%b",
                     x.tag, rif.amp, rif.freq, rif.busy, rif.calm, rif.alarm,
                     x.amp, x.freq, x.busy, x.calm, x.alarm);
        end
    endtask

    // Two settle ticks, then an EVAL cycle with the given flags.
    task automatic round(input string tag, input logic [2:0] st, input logic g, input logic e,
                         input logic [2:0] pa, input logic [2:0] pf, input logic pal,
                         input logic [2:0] na, input logic [2:0] nf,
                         input logic nb, input logic nc, input logic nal);
        rif.status = 3'd3; rif.gedaald = 1'b0; rif.gelijk = 1'b0;
        rif.sample_tick = 1'b1; cyc();
        rif.sample_tick = 1'b0; cyc();
        rif.sample_tick = 1'b1;
        expect_out({tag, "_pre_eval"}, pa, pf, 1'b1, 1'b0, pal);
        cyc();
        check_out();
        rif.sample_tick = 1'b0;
        rif.status = st; rif.gedaald = g; rif.gelijk = e;
        expect_out(tag, na, nf, nb, nc, nal);
        cyc();
        check_out();
        rif.status = 3'd3; rif.gedaald = 1'b0; rif.gelijk = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [2:0] pa, pf;
`ifdef ROCK_WATCHDOG_EN
        wd = 1'b1;
`else
        wd = 1'b0;
`endif
        tbl[0]  = '{3'd3, 1'b1, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0};
        tbl[1]  = '{3'd3, 1'b1, 1'b0, 3'd4, 3'd2, 1'b1, 1'b0};
        tbl[2]  = '{3'd3, 1'b1, 1'b0, 3'd5, 3'd2, 1'b1, 1'b0};
        tbl[3]  = '{3'd3, 1'b0, 1'b1, 3'd5, 3'd3, 1'b1, 1'b0};
        tbl[4]  = '{3'd3, 1'b0, 1'b0, 3'd4, 3'd3, 1'b1, 1'b0};
        tbl[5]  = '{3'd3, 1'b1, 1'b1, 3'd3, 3'd3, 1'b1, 1'b0};
        tbl[6]  = '{3'd3, 1'b0, 1'b1, 3'd3, 3'd2, 1'b1, 1'b0};
        tbl[7]  = '{3'd3, 1'b0, 1'b0, 3'd4, 3'd2, 1'b1, 1'b0};
        tbl[8]  = '{3'd3, 1'b1, 1'b0, 3'd5, 3'd2, 1'b1, 1'b0};
        tbl[9]  = '{3'd3, 1'b1, 1'b0, 3'd6, 3'd2, 1'b1, 1'b0};
        tbl[10] = '{3'd3, 1'b1, 1'b0, 3'd7, 3'd2, 1'b1, 1'b0};
        tbl[11] = '{3'd3, 1'b1, 1'b0, 3'd7, 3'd2, 1'b1, 1'b0};
        tbl[12] = '{3'd3, 1'b1, 1'b0, 3'd6, 3'd2, 1'b1, 1'b0};
        tbl[13] = '{3'd0, 1'b0, 1'b0, 3'd6, 3'd2, 1'b0, 1'b1};

        reset = 1'b1;
        rif.enable = 1'b0; rif.sample_tick = 1'b0;
        rif.status = 3'd3; rif.gedaald = 1'b0; rif.gelijk = 1'b0;
        expect_out("reset_state", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        check_out();
        reset = 1'b0;
        cyc();

        rif.enable = 1'b1;
        expect_out("enable_start", 3'd2, 3'd2, 1'b1, 1'b0, 1'b0);
        cyc();
        check_out();

        pa = 3'd2; pf = 3'd2;
        for (int i = 0; i < 14; i++) begin
            round($sformatf("vec%0d", i), tbl[i].st, tbl[i].g, tbl[i].e, pa, pf, 1'b0,
                  tbl[i].amp, tbl[i].freq, tbl[i].busy, tbl[i].calm, 1'b0);
            pa = tbl[i].amp; pf = tbl[i].freq;
        end

        rif.sample_tick = 1'b1; rif.status = 3'd0;
        expect_out("calm_tick_quiet", 3'd6, 3'd2, 1'b0, 1'b1, 1'b0);
        cyc();
        check_out();
        rif.status = 3'd2;
        expect_out("calm_to_settle", 3'd6, 3'd2, 1'b1, 1'b0, 1'b0);
        cyc();
        check_out();
        rif.sample_tick = 1'b0; rif.status = 3'd3;

        rif.enable = 1'b0;
        expect_out("disable_zero", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        check_out();
        rif.sample_tick = 1'b1;
        cyc();
        expect_out("idle_tick_ignored", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        check_out();
        rif.sample_tick = 1'b0;

        rif.enable = 1'b1;
        expect_out("reenable", 3'd2, 3'd2, 1'b1, 1'b0, 1'b0);
        cyc();
        check_out();
        rif.sample_tick = 1'b1; cyc();
        rif.sample_tick = 1'b0; cyc();
        rif.sample_tick = 1'b1; cyc();
        rif.sample_tick = 1'b0; rif.gedaald = 1'b1; rif.enable = 1'b0;
        expect_out("disable_in_eval", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        check_out();
        rif.gedaald = 1'b0; rif.enable = 1'b1;
        expect_out("enable_after_eval_drop", 3'd2, 3'd2, 1'b1, 1'b0, 1'b0);
        cyc();
        check_out();
        round("fresh_knob_dir", 3'd3, 1'b1, 1'b0, 3'd2, 3'd2, 1'b0, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0);

        #2;
        reset = 1'b1;
        #1;
        expect_out("async_reset", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        check_out();
        cyc();
        reset = 1'b0;
        expect_out("after_reset_enable", 3'd2, 3'd2, 1'b1, 1'b0, 1'b0);
        cyc();
        check_out();

        round("worse1", 3'd3, 1'b0, 1'b0, 3'd2, 3'd2, 1'b0, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0);
        round("worse2", 3'd3, 1'b0, 1'b0, 3'd2, 3'd1, 1'b0, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0);
        round("worse3_freq_floor", 3'd3, 1'b0, 1'b0, 3'd3, 3'd1, 1'b0, 3'd3, 3'd1, 1'b1, 1'b0, 1'b0);
        if (wd) begin
            round("worse4_trip", 3'd3, 1'b0, 1'b0, 3'd3, 3'd1, 1'b0, 3'd2, 3'd2, 1'b1, 1'b0, 1'b1);
        end else begin
            round("worse4_no_alarm", 3'd3, 1'b0, 1'b0, 3'd3, 3'd1, 1'b0, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0);
        end
        rif.enable = 1'b0;
        expect_out("alarm_cleared_idle", 3'd0, 3'd0, 1'b0, 1'b0, 1'b0);
        cyc();
        check_out();

        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d queued, want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
